// File: rtl/seq_divider32_if.sv
// Handshake bundle between the execute-stage controller and the sequential divider.
// The controller side is the master; the divider is the slave.
interface seq_divider32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider32.sv
// Restoring divider, one quotient bit per clock, signed or unsigned, truncating.
// Magnitudes are divided and signs are applied in a final FIX cycle.
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  seq_divider32_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic             sign_dvd_q, sign_dvd_d;
  logic             sign_dvs_q, sign_dvs_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             ld_sign_dvd, ld_sign_dvs;
  logic [WIDTH:0]   r_shift, sub;

  assign ld_sign_dvd = bus.is_signed & bus.dividend[WIDTH-1];
  assign ld_sign_dvs = bus.is_signed & bus.divisor[WIDTH-1];

  // The partial remainder stays below the divisor, so its top bit is always zero
  // between steps and only the shifted value needs the extra bit.
  assign r_shift = {rem_q, quo_q[WIDTH-1]};
  assign sub     = r_shift + {1'b1, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    orig_d      = orig_q;
    sign_dvd_d  = sign_dvd_q;
    sign_dvs_d  = sign_dvs_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_dvd_d = ld_sign_dvd;
          sign_dvs_d = ld_sign_dvs;
          quo_d      = ld_sign_dvd ? -bus.dividend : bus.dividend;
          dvs_d      = ld_sign_dvs ? -bus.divisor : bus.divisor;
          orig_d     = bus.dividend;
          rem_d      = '0;
          cnt_d      = '0;
          zero_d     = (bus.divisor == '0);
          busy_d     = 1'b1;
          state_d    = (bus.divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        quo_d = {quo_q[WIDTH-2:0], ~sub[WIDTH]};
        rem_d = sub[WIDTH] ? r_shift[WIDTH-1:0] : sub[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = orig_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = (sign_dvd_q ^ sign_dvs_q) ? -quo_q : quo_q;
          remainder_d = sign_dvd_q ? -rem_q : rem_q;
          dbz_d       = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      orig_q      <= '0;
      sign_dvd_q  <= 1'b0;
      sign_dvs_q  <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      orig_q      <= orig_d;
      sign_dvd_q  <= sign_dvd_d;
      sign_dvs_q  <= sign_dvs_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule
